umi_tx_arbiter: RTL and testbench
=================================

Name: umi_tx_arbiter

Overview:
- Round-robin arbiter sharing one 256-bit UMI TX port among N requesters, e.g. several cores or DMA engines feeding the single testbench-side send path.
- Sits between the requesters' UMI TX outputs and the shared consumer, which is the TX drain / pi_zmq_send loop.
- Has one registered output stage, so the packet presented downstream is stable and comes from exactly one source.
- Full throughput: a new packet can be captured in the same cycle the held packet is accepted.

Parameters:
- N, 4, number of requesters (2..16).
- DW, 256, UMI packet width in bits.
- IW, $clog2(N), width of the source-index field.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- umi_packet_in  input  N*DW  requester packets; requester i occupies bits [(i+1)*DW-1 : i*DW].
- umi_valid_in  input  N  per-requester valid.
- umi_ready_in  output  N  per-requester ready (combinational grant).
- umi_packet_out  output  DW  registered packet to the shared consumer.
- umi_valid_out  output  1  registered valid.
- umi_ready_out  input  1  consumer ready.
- grant_id  output  IW  index of the requester whose packet is held in the output register.

Behaviour:
- Reset values (rst high at a posedge):
  - umi_valid_out=0, umi_packet_out=0, grant_id=0.
  - Round-robin pointer ptr=0.
  - umi_ready_in=0 during the reset cycle.
- Output slot state:
  - free = !umi_valid_out | umi_ready_out.
  - The output slot is EMPTY when umi_valid_out=0 and FULL when umi_valid_out=1.
- Selection (combinational):
  - sel = first i with umi_valid_in[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - any = |umi_valid_in.
- Ready:
  - umi_ready_in[sel] = free & any & !rst.
  - All other ready bits are 0.
  - At most one bit is set.
  - Ready never depends on umi_packet_in.
- Capture (at the posedge where free & any):
  - umi_packet_out <= packet[sel], grant_id <= sel, umi_valid_out <= 1.
  - ptr <= (sel+1) mod N; wraps at N-1 → 0.
- Drain:
  - If umi_valid_out & umi_ready_out and no capture in that cycle: umi_valid_out <= 0.
  - Packet and grant_id hold their last values.
- Simultaneous drain and capture: the new packet replaces the old one in the same edge, umi_valid_out stays 1, and back-to-back 1 packet/cycle is sustained.
- Stalled output:
  - While umi_valid_out=1 and umi_ready_out=0, umi_packet_out, grant_id and ptr are frozen and umi_ready_in is all zero.
  - Requesters must hold valid and packet until they see ready; a requester may not drop valid before ready (bench assertion).
- Latency: a packet handshaken on the input at edge k is first visible on the output after edge k; one cycle of latency.
- Fairness: with all N requesters continuously valid, each is granted exactly once in every N consecutive grants. Maximum wait is N-1 grants.
- ptr changes only on a capture; idle cycles do not rotate it.
- Reset mid-operation: a held output packet is discarded (valid->0). No ready pulse is issued in the reset cycle, so no requester loses a packet.
- umi_valid_out must not glitch combinationally; it comes straight from a flop.

Test Plan:
- Single requester: only in[2] valid with packet 0xA5…A5, ready_out=1. Expect ready_in=4'b0100 for 1 cycle, then valid_out=1 with packet A5…A5 and grant_id=2 in the next cycle, then ptr=3.
- All four requesters valid continuously, ready_out=1, for 8 cycles. Expect grant_id sequence 0,1,2,3,0,1,2,3, valid_out=1 every cycle after the first, and each ready_in bit high in 2 of the 8 cycles.
- Backpressure: in[0] and in[1] valid, ready_out=0 for 5 cycles after the first capture. Expect packet_out and grant_id=0 frozen, ready_in=0 throughout. Set ready_out=1: expect in[1] captured in that same cycle and grant_id=1 next.
- Wrap-around: ptr=3 after granting requester 2, then in[0] and in[3] valid. Expect grant to 3 first, then 0, and ptr wraps 3→0→1.
- Idle does not rotate: grant requester 1 (ptr=2), then 10 idle cycles, then in[0] and in[2] valid. Expect requester 2 granted first.
- Reset mid-stall: valid_out=1, ready_out=0, assert rst for 1 cycle. Expect valid_out=0, ptr=0 and ready_in=0 during reset. On the next cycle with in[1] and in[3] valid, expect grant to 1.

Source files
------------

// File: rtl/umi_tx_arbiter.sv
// Round-robin arbiter sharing one UMI TX port among N requesters.
// A single registered output slot is refilled in the same cycle it drains.
module umi_tx_arbiter #(
  parameter int N  = 4,
  parameter int DW = 256,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] umi_packet_in,
  input  logic [N-1:0]    umi_valid_in,
  output logic [N-1:0]    umi_ready_in,
  output logic [DW-1:0]   umi_packet_out,
  output logic            umi_valid_out,
  input  logic            umi_ready_out,
  output logic [IW-1:0]   grant_id
);

  localparam logic [IW:0]   LP_N    = (IW+1)'(N);
  localparam logic [IW-1:0] LP_LAST = IW'(N - 1);

  logic [IW-1:0]  r_ptr;
  logic [DW-1:0]  r_packet;
  logic           r_valid;
  logic [IW-1:0]  r_grant;

  logic           w_free;
  logic           w_any;
  logic           w_capture;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;
  logic [IW-1:0]  w_sel;
  logic [IW-1:0]  w_ptr_nxt;

  assign w_free    = !r_valid | umi_ready_out;
  assign w_any     = |umi_valid_in;
  assign w_capture = w_free & w_any & !rst;

  // Rotate the request vector so bit 0 is the requester at the pointer.
  assign w_dbl = {umi_valid_in, umi_valid_in} >> r_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Lowest set bit of the rotated vector is the rotation offset of the winner.
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IW'(k);
      end else begin
        w_off = w_off;
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel     = (w_sum >= LP_N) ? IW'(w_sum - LP_N) : IW'(w_sum);
  assign w_ptr_nxt = (w_sel == LP_LAST) ? '0 : w_sel + IW'(1);

  assign umi_ready_in = w_capture ? (N'(1) << w_sel) : '0;

  // Output slot: capture on free & any, otherwise drain or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_packet <= '0;
      r_grant  <= '0;
      r_ptr    <= '0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_packet <= umi_packet_in[w_sel*DW +: DW];
      r_grant  <= w_sel;
      r_ptr    <= w_ptr_nxt;
    end else if (r_valid & umi_ready_out) begin
      r_valid  <= 1'b0;
    end else begin
      r_valid  <= r_valid;
    end
  end

  assign umi_packet_out = r_packet;
  assign umi_valid_out  = r_valid;
  assign grant_id       = r_grant;

endmodule

// File: tb/tb_umi_tx_arbiter.sv
// Directed self-checking bench for umi_tx_arbiter (N=4, DW=256).
module tb_umi_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] umi_packet_in;
  logic [N-1:0]    umi_valid_in;
  logic [N-1:0]    umi_ready_in;
  logic [DW-1:0]   umi_packet_out;
  logic            umi_valid_out;
  logic            umi_ready_out;
  logic [IW-1:0]   grant_id;

  int n_vec = 0;
  int n_err = 0;

  umi_tx_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .umi_packet_in  (umi_packet_in),
    .umi_valid_in   (umi_valid_in),
    .umi_ready_in   (umi_ready_in),
    .umi_packet_out (umi_packet_out),
    .umi_valid_out  (umi_valid_out),
    .umi_ready_out  (umi_ready_out),
    .grant_id       (grant_id)
  );

  always #5 clk = ~clk;

  // Requester i always offers {32{A3+i}}; requester 2 therefore sends A5..A5.
  function automatic logic [DW-1:0] pat(input int i);
    logic [7:0] b;
    b = 8'hA3 + 8'(i);
    return {32{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    umi_valid_in = '0;
    umi_ready_out = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    umi_valid_in = 4'b1111;
    umi_ready_out = 1'b1;
    #1;
    n_vec++;
    if (umi_ready_in !== 4'b0000) begin
      $display("FAIL reset_ready_pre: got %b want 0000", umi_ready_in); n_err++;
    end
    tick();
    n_vec++;
    if (umi_valid_out !== 1'b0) begin
      $display("FAIL reset_valid: got %b want 0", umi_valid_out); n_err++;
    end
    n_vec++;
    if (umi_packet_out !== '0) begin
      $display("FAIL reset_packet: got %h want 0", umi_packet_out); n_err++;
    end
    n_vec++;
    if (grant_id !== 2'd0) begin
      $display("FAIL reset_grant: got %0d want 0", grant_id); n_err++;
    end
    n_vec++;
    if (umi_ready_in !== 4'b0000) begin
      $display("FAIL reset_ready: got %b want 0000", umi_ready_in); n_err++;
    end
    rst = 1'b0;
    umi_valid_in = '0;
    #1;
  endtask

  // Single requester, then wrap-around of the pointer 3 -> 0 -> 1.
  task automatic test_single_and_wrap();
    do_reset();
    umi_valid_in = 4'b0100;
    #1;
    n_vec++;
    if (umi_ready_in !== 4'b0100) begin
      $display("FAIL single_ready: got %b want 0100", umi_ready_in); n_err++;
    end
    tick();
    umi_valid_in = 4'b0000;
    #1;
    n_vec++;
    if (umi_valid_out !== 1'b1 || umi_packet_out !== {32{8'hA5}} || grant_id !== 2'd2) begin
      $display("FAIL single_out: got v=%b g=%0d p=%h want v=1 g=2 p=A5..", umi_valid_out, grant_id, umi_packet_out);
      n_err++;
    end
    n_vec++;
    if (umi_ready_in !== 4'b0000) begin
      $display("FAIL single_ready_after: got %b want 0000", umi_ready_in); n_err++;
    end
    umi_valid_in = 4'b1001;
    #1;
    n_vec++;
    if (umi_ready_in !== 4'b1000) begin
      $display("FAIL wrap_first: got %b want 1000", umi_ready_in); n_err++;
    end
    tick();
    umi_valid_in = 4'b0001;
    #1;
    n_vec++;
    if (grant_id !== 2'd3 || umi_packet_out !== pat(3) || umi_ready_in !== 4'b0001) begin
      $display("FAIL wrap_second: got g=%0d rdy=%b want g=3 rdy=0001", grant_id, umi_ready_in); n_err++;
    end
    tick();
    umi_valid_in = 4'b0011;
    #1;
    n_vec++;
    if (grant_id !== 2'd0 || umi_ready_in !== 4'b0010) begin
      $display("FAIL wrap_ptr1: got g=%0d rdy=%b want g=0 rdy=0010", grant_id, umi_ready_in); n_err++;
    end
    tick();
    umi_valid_in = 4'b0000;
    tick();
    n_vec++;
    if (umi_valid_out !== 1'b0 || grant_id !== 2'd1 || umi_packet_out !== pat(1)) begin
      $display("FAIL drain_hold: got v=%b g=%0d want v=0 g=1", umi_valid_out, grant_id); n_err++;
    end
  endtask

  task automatic test_round_robin();
    int cnt [N];
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    umi_valid_in = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      for (int i = 0; i < N; i++) cnt[i] += int'(umi_ready_in[i]);
      n_vec++;
      if (umi_ready_in !== (4'b0001 << (c % 4))) begin
        $display("FAIL rr_ready[%0d]: got %b want %b", c, umi_ready_in, 4'b0001 << (c % 4)); n_err++;
      end
      tick();
      n_vec++;
      if (umi_valid_out !== 1'b1 || grant_id !== 2'(c % 4) || umi_packet_out !== pat(c % 4)) begin
        $display("FAIL rr_grant[%0d]: got v=%b g=%0d want v=1 g=%0d", c, umi_valid_out, grant_id, c % 4); n_err++;
      end
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (cnt[i] !== 2) begin
        $display("FAIL rr_count[%0d]: got %0d want 2", i, cnt[i]); n_err++;
      end
    end
    umi_valid_in = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    umi_valid_in = 4'b0011;
    #1;
    n_vec++;
    if (umi_ready_in !== 4'b0001) begin
      $display("FAIL bp_first: got %b want 0001", umi_ready_in); n_err++;
    end
    tick();
    umi_ready_out = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (umi_ready_in !== 4'b0000 || umi_valid_out !== 1'b1 || grant_id !== 2'd0 || umi_packet_out !== pat(0)) begin
        $display("FAIL bp_stall[%0d]: got rdy=%b v=%b g=%0d want rdy=0000 v=1 g=0", c, umi_ready_in, umi_valid_out, grant_id);
        n_err++;
      end
      tick();
    end
    umi_ready_out = 1'b1;
    #1;
    n_vec++;
    if (umi_ready_in !== 4'b0010) begin
      $display("FAIL bp_release: got %b want 0010", umi_ready_in); n_err++;
    end
    tick();
    umi_valid_in = 4'b0001;
    #1;
    n_vec++;
    if (grant_id !== 2'd1 || umi_packet_out !== pat(1) || umi_ready_in !== 4'b0001) begin
      $display("FAIL bp_after: got g=%0d rdy=%b want g=1 rdy=0001", grant_id, umi_ready_in); n_err++;
    end
    tick();
    umi_valid_in = 4'b0000;
    tick();
    n_vec++;
    if (umi_valid_out !== 1'b0 || grant_id !== 2'd0) begin
      $display("FAIL bp_drain: got v=%b g=%0d want v=0 g=0", umi_valid_out, grant_id); n_err++;
    end
  endtask

  task automatic test_idle_no_rotate();
    do_reset();
    umi_valid_in = 4'b0010;
    tick();
    umi_valid_in = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      tick();
    end
    n_vec++;
    if (umi_valid_out !== 1'b0 || grant_id !== 2'd1) begin
      $display("FAIL idle_state: got v=%b g=%0d want v=0 g=1", umi_valid_out, grant_id); n_err++;
    end
    umi_valid_in = 4'b0101;
    #1;
    n_vec++;
    if (umi_ready_in !== 4'b0100) begin
      $display("FAIL idle_next: got %b want 0100", umi_ready_in); n_err++;
    end
    tick();
    umi_valid_in = 4'b0001;
    tick();
    n_vec++;
    if (grant_id !== 2'd0 || umi_valid_out !== 1'b1) begin
      $display("FAIL idle_second: got g=%0d v=%b want g=0 v=1", grant_id, umi_valid_out); n_err++;
    end
    umi_valid_in = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    umi_valid_in = 4'b0010;
    tick();
    umi_valid_in = 4'b0000;
    umi_ready_out = 1'b0;
    tick();
    n_vec++;
    if (umi_valid_out !== 1'b1 || grant_id !== 2'd1) begin
      $display("FAIL mid_stall_pre: got v=%b g=%0d want v=1 g=1", umi_valid_out, grant_id); n_err++;
    end
    rst = 1'b1;
    umi_ready_out = 1'b1;
    umi_valid_in = 4'b1010;
    #1;
    n_vec++;
    if (umi_ready_in !== 4'b0000) begin
      $display("FAIL mid_reset_ready: got %b want 0000", umi_ready_in); n_err++;
    end
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (umi_valid_out !== 1'b0 || grant_id !== 2'd0) begin
      $display("FAIL mid_reset_out: got v=%b g=%0d want v=0 g=0", umi_valid_out, grant_id); n_err++;
    end
    n_vec++;
    if (umi_ready_in !== 4'b0010) begin
      $display("FAIL mid_reset_ptr: got %b want 0010", umi_ready_in); n_err++;
    end
    tick();
    n_vec++;
    if (grant_id !== 2'd1 || umi_valid_out !== 1'b1 || umi_packet_out !== pat(1)) begin
      $display("FAIL mid_reset_grant: got g=%0d v=%b want g=1 v=1", grant_id, umi_valid_out); n_err++;
    end
    umi_valid_in = 4'b0000;
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) umi_packet_in[i*DW +: DW] = pat(i);
    rst = 1'b1;
    umi_valid_in = '0;
    umi_ready_out = 1'b1;
    #1;
    test_reset();
    test_single_and_wrap();
    test_round_robin();
    test_backpressure();
    test_idle_no_rotate();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
